// File: rtl/cond_pipe_ctrl.sv
// Pipeline back-end for the ARM-subset controller: carries decoded control from E to W,
// evaluates conditions against the flags register, resolves branches early in D and counts retirements.
module cond_pipe_ctrl #(
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ValidD,
  input  logic [3:0]                CondD,
  input  logic                      BranchD,
  input  logic                      RegWriteD,
  input  logic                      MemWriteD,
  input  logic                      PCSrcD,
  input  logic                      NoWriteD,
  input  logic [1:0]                FlagWriteD,
  input  logic [CTRL_W-1:0]         CtrlD,
  input  logic                      StallE,
  input  logic                      FlushE,
  input  logic [3:0]                ALUFlagsE,
  output logic                      BranchTakenD,
  output logic                      CondExE,
  output logic [3:0]                FlagsE,
  output logic [DEPTH-1:0]          RegWriteP,
  output logic [DEPTH-1:0]          MemWriteP,
  output logic [DEPTH-1:0]          PCSrcP,
  output logic [DEPTH*CTRL_W-1:0]   CtrlP,
  output logic                      PCWrPendingF,
  output logic [CNT_W-1:0]          RetireCnt
);

  // ARM condition table; flags are {N,Z,C,V}
  function automatic logic condPass(input logic [3:0] cond, input logic [3:0] flags);
    logic result;
    case (cond)
      4'b0000: result = flags[2];
      4'b0001: result = ~flags[2];
      4'b0010: result = flags[1];
      4'b0011: result = ~flags[1];
      4'b0100: result = flags[3];
      4'b0101: result = ~flags[3];
      4'b0110: result = flags[0];
      4'b0111: result = ~flags[0];
      4'b1000: result = flags[1] & ~flags[2];
      4'b1001: result = ~flags[1] | flags[2];
      4'b1010: result = (flags[3] == flags[0]);
      4'b1011: result = (flags[3] != flags[0]);
      4'b1100: result = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: result = flags[2] | (flags[3] != flags[0]);
      4'b1110: result = 1'b1;
      4'b1111: result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

  logic                          validE_r;
  logic [3:0]                    condE_r;
  logic                          regWriteE_r;
  logic                          memWriteE_r;
  logic                          pcSrcE_r;
  logic                          noWriteE_r;
  logic [1:0]                    flagWriteE_r;
  logic [CTRL_W-1:0]             ctrlE_r;
  logic [3:0]                    flagsE_r;
  logic [DEPTH-1:1]              regWritePipe_r;
  logic [DEPTH-1:1]              memWritePipe_r;
  logic [DEPTH-1:1]              pcSrcPipe_r;
  logic [DEPTH-1:1]              execPipe_r;
  logic [DEPTH-1:1][CTRL_W-1:0]  ctrlPipe_r;
  logic [CNT_W-1:0]              retireCnt_r;

  logic                          condExE_s;
  logic                          regWrite0_s;
  logic                          memWrite0_s;
  logic                          pcSrc0_s;
  logic [3:0]                    flagsNext_s;
  logic                          branchTaken_s;
  logic                          pcWrPending_s;

  // E-stage condition, write gating, flag forwarding and early branch resolution
  always_comb begin
    condExE_s   = validE_r & condPass(condE_r, flagsE_r);
    regWrite0_s = regWriteE_r & condExE_s & ~noWriteE_r;
    memWrite0_s = memWriteE_r & condExE_s;
    pcSrc0_s    = pcSrcE_r & condExE_s;
    flagsNext_s[3:2] = (flagWriteE_r[1] & condExE_s) ? ALUFlagsE[3:2] : flagsE_r[3:2];
    flagsNext_s[1:0] = (flagWriteE_r[0] & condExE_s) ? ALUFlagsE[1:0] : flagsE_r[1:0];
    branchTaken_s = BranchD & ValidD & condPass(CondD, flagsNext_s);
    // W stage is excluded: its PC write lands this edge and is no longer pending
    pcWrPending_s = PCSrcD | pcSrcE_r;
    for (int i = 1; i < DEPTH - 1; i++) begin
      pcWrPending_s = pcWrPending_s | pcSrcPipe_r[i];
    end
  end

  // Stage registers, flags register and saturating retirement counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      validE_r       <= 1'b0;
      condE_r        <= 4'b0000;
      regWriteE_r    <= 1'b0;
      memWriteE_r    <= 1'b0;
      pcSrcE_r       <= 1'b0;
      noWriteE_r     <= 1'b0;
      flagWriteE_r   <= 2'b00;
      ctrlE_r        <= '0;
      flagsE_r       <= 4'b0000;
      regWritePipe_r <= '0;
      memWritePipe_r <= '0;
      pcSrcPipe_r    <= '0;
      execPipe_r     <= '0;
      ctrlPipe_r     <= '0;
      retireCnt_r    <= '0;
    end else begin
      if (FlushE) begin
        validE_r     <= 1'b0;
        condE_r      <= 4'b0000;
        regWriteE_r  <= 1'b0;
        memWriteE_r  <= 1'b0;
        pcSrcE_r     <= 1'b0;
        noWriteE_r   <= 1'b0;
        flagWriteE_r <= 2'b00;
        ctrlE_r      <= '0;
      end else if (!StallE) begin
        validE_r     <= ValidD;
        condE_r      <= CondD;
        regWriteE_r  <= RegWriteD;
        memWriteE_r  <= MemWriteD;
        pcSrcE_r     <= PCSrcD;
        noWriteE_r   <= NoWriteD;
        flagWriteE_r <= FlagWriteD;
        ctrlE_r      <= CtrlD;
      end

      // A stalled E instruction commits its flags only once, on the cycle it leaves E
      if (!StallE) begin
        flagsE_r <= flagsNext_s;
      end

      if (StallE) begin
        regWritePipe_r[1] <= 1'b0;
        memWritePipe_r[1] <= 1'b0;
        pcSrcPipe_r[1]    <= 1'b0;
        execPipe_r[1]     <= 1'b0;
        ctrlPipe_r[1]     <= '0;
      end else begin
        regWritePipe_r[1] <= regWrite0_s;
        memWritePipe_r[1] <= memWrite0_s;
        pcSrcPipe_r[1]    <= pcSrc0_s;
        execPipe_r[1]     <= condExE_s;
        ctrlPipe_r[1]     <= ctrlE_r;
      end

      for (int i = 2; i < DEPTH; i++) begin
        regWritePipe_r[i] <= regWritePipe_r[i-1];
        memWritePipe_r[i] <= memWritePipe_r[i-1];
        pcSrcPipe_r[i]    <= pcSrcPipe_r[i-1];
        execPipe_r[i]     <= execPipe_r[i-1];
        ctrlPipe_r[i]     <= ctrlPipe_r[i-1];
      end

      if (execPipe_r[DEPTH-1] && (retireCnt_r != {CNT_W{1'b1}})) begin
        retireCnt_r <= retireCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign BranchTakenD = branchTaken_s;
  assign CondExE      = condExE_s;
  assign FlagsE       = flagsE_r;
  assign RegWriteP    = {regWritePipe_r, regWrite0_s};
  assign MemWriteP    = {memWritePipe_r, memWrite0_s};
  assign PCSrcP       = {pcSrcPipe_r, pcSrc0_s};
  assign CtrlP        = {ctrlPipe_r, ctrlE_r};
  assign PCWrPendingF = pcWrPending_s;
  assign RetireCnt    = retireCnt_r;

endmodule

// File: tb/tb_cond_pipe_ctrl.sv
// Scoreboard bench for cond_pipe_ctrl: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cond_pipe_ctrl;
  localparam int CTRL_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;

  localparam int S_BR   = 0;
  localparam int S_CEX  = 1;
  localparam int S_FLG  = 2;
  localparam int S_RW   = 3;
  localparam int S_MW   = 4;
  localparam int S_PCS  = 5;
  localparam int S_PEND = 6;
  localparam int S_RET  = 7;
  localparam int S_CTRL = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    ValidD;
  logic [3:0]              CondD;
  logic                    BranchD;
  logic                    RegWriteD;
  logic                    MemWriteD;
  logic                    PCSrcD;
  logic                    NoWriteD;
  logic [1:0]              FlagWriteD;
  logic [CTRL_W-1:0]       CtrlD;
  logic                    StallE;
  logic                    FlushE;
  logic [3:0]              ALUFlagsE;
  logic                    BranchTakenD;
  logic                    CondExE;
  logic [3:0]              FlagsE;
  logic [DEPTH-1:0]        RegWriteP;
  logic [DEPTH-1:0]        MemWriteP;
  logic [DEPTH-1:0]        PCSrcP;
  logic [DEPTH*CTRL_W-1:0] CtrlP;
  logic                    PCWrPendingF;
  logic [CNT_W-1:0]        RetireCnt;

  always #5 clk = ~clk;

  cond_pipe_ctrl #(.CTRL_W(CTRL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .CondD(CondD), .BranchD(BranchD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .PCSrcD(PCSrcD), .NoWriteD(NoWriteD),
    .FlagWriteD(FlagWriteD), .CtrlD(CtrlD), .StallE(StallE), .FlushE(FlushE),
    .ALUFlagsE(ALUFlagsE), .BranchTakenD(BranchTakenD), .CondExE(CondExE), .FlagsE(FlagsE),
    .RegWriteP(RegWriteP), .MemWriteP(MemWriteP), .PCSrcP(PCSrcP), .CtrlP(CtrlP),
    .PCWrPendingF(PCWrPendingF), .RetireCnt(RetireCnt)
  );

  typedef struct {
    int          id;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   nTests = 0;
  int   nFail  = 0;

  function automatic logic [31:0] sigVal(input int id);
    case (id)
      S_BR:    return {31'd0, BranchTakenD};
      S_CEX:   return {31'd0, CondExE};
      S_FLG:   return {28'd0, FlagsE};
      S_RW:    return {28'd0, RegWriteP};
      S_MW:    return {28'd0, MemWriteP};
      S_PCS:   return {28'd0, PCSrcP};
      S_PEND:  return {31'd0, PCWrPendingF};
      S_RET:   return {30'd0, RetireCnt};
      S_CTRL:  return {16'd0, CtrlP};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  exp_t        monItem;
  logic [31:0] monAct;

  // Monitor: every expectation queued during this cycle is checked at the falling edge
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      monItem = expQ.pop_front();
      monAct  = sigVal(monItem.id);
      nTests++;
      if (monAct !== monItem.val) begin
        nFail++;
        $display("FAIL %s: actual=%0h required=%0h at %0t", monItem.name, monAct, monItem.val, $time);
      end
    end
  end

  task automatic expectSig(input int id, input logic [31:0] val, input string name);
    exp_t e;
    e.id = id; e.val = val; e.name = name;
    expQ.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idleD;
    ValidD = 1'b0; CondD = 4'hE; BranchD = 1'b0; RegWriteD = 1'b0; MemWriteD = 1'b0;
    PCSrcD = 1'b0; NoWriteD = 1'b0; FlagWriteD = 2'b00; CtrlD = 4'h0;
  endtask

  task automatic doReset;
    reset = 1'b0; idleD(); StallE = 1'b0; FlushE = 1'b0; ALUFlagsE = 4'h0;
    tick();
    reset = 1'b1;
  endtask

  // Run a flag-setting compare through E so that FlagsE becomes f with E empty
  task automatic setFlags(input logic [3:0] f);
    idleD(); ValidD = 1'b1; NoWriteD = 1'b1; RegWriteD = 1'b1; FlagWriteD = 2'b11;
    tick();
    idleD(); ALUFlagsE = f;
    tick();
    ALUFlagsE = 4'h0;
  endtask

  task automatic condSweep(input logic [3:0] f, input logic [15:0] pat);
    setFlags(f);
    expectSig(S_FLG, {28'd0, f}, "flagsSet");
    for (int c = 0; c < 16; c++) begin
      idleD(); ValidD = 1'b1; BranchD = 1'b1; CondD = c[3:0];
      expectSig(S_BR, {31'd0, pat[c]}, "condTable");
      tick();
    end
  endtask

  initial begin
    // Reset held two edges with a live instruction in D
    reset = 1'b0; idleD(); StallE = 1'b0; FlushE = 1'b0; ALUFlagsE = 4'h0;
    ValidD = 1'b1; RegWriteD = 1'b1;
    tick(); tick();
    expectSig(S_RW, 32'h0, "rstRegWriteP"); expectSig(S_MW, 32'h0, "rstMemWriteP");
    expectSig(S_PCS, 32'h0, "rstPCSrcP");   expectSig(S_FLG, 32'h0, "rstFlags");
    expectSig(S_RET, 32'h0, "rstRetire");   expectSig(S_CEX, 32'h0, "rstCondEx");
    tick();

    // ADDS in E sets Z; BEQ in D resolves taken through forwarded flags
    reset = 1'b1; idleD();
    ValidD = 1'b1; RegWriteD = 1'b1; FlagWriteD = 2'b11;
    tick();
    idleD(); ValidD = 1'b1; BranchD = 1'b1; CondD = 4'b0000; ALUFlagsE = 4'b0100;
    expectSig(S_BR, 32'h1, "fwdBranch"); expectSig(S_CEX, 32'h1, "addsCondEx");
    expectSig(S_RW, 32'h1, "addsRw0");   expectSig(S_FLG, 32'h0, "flagsBefore");
    tick();
    idleD(); ALUFlagsE = 4'h0;
    expectSig(S_FLG, 32'h4, "flagsAfter"); expectSig(S_CEX, 32'h1, "beqCondEx");
    expectSig(S_RW, 32'h2, "addsRw1");     expectSig(S_BR, 32'h0, "noBranch");
    tick();
    expectSig(S_RW, 32'h4, "addsRw2"); tick();
    expectSig(S_RW, 32'h8, "addsRw3"); expectSig(S_RET, 32'h0, "retire0"); tick();
    expectSig(S_RET, 32'h1, "retire1"); expectSig(S_RW, 32'h0, "rwDrained"); tick();
    expectSig(S_RET, 32'h2, "retire2"); tick();

    // NE fails against Z=1: no register write, no retirement
    doReset();
    ValidD = 1'b1; RegWriteD = 1'b1; NoWriteD = 1'b1; FlagWriteD = 2'b11;
    tick();
    idleD(); ValidD = 1'b1; CondD = 4'b0001; RegWriteD = 1'b1; ALUFlagsE = 4'b0100;
    expectSig(S_RW, 32'h0, "cmpNoWrite"); expectSig(S_CEX, 32'h1, "cmpCondEx");
    tick();
    idleD(); ALUFlagsE = 4'h0;
    expectSig(S_CEX, 32'h0, "neCondEx"); expectSig(S_RW, 32'h0, "neRw"); expectSig(S_FLG, 32'h4, "cmpFlags");
    tick();
    expectSig(S_RW, 32'h0, "neRw1"); tick();
    expectSig(S_RW, 32'h0, "neRw2"); expectSig(S_RET, 32'h0, "neRet0"); tick();
    expectSig(S_RET, 32'h1, "cmpRetired"); tick();
    expectSig(S_RET, 32'h1, "neNotRetired"); tick();

    // Two-cycle stall of an ADDS in E
    doReset();
    ValidD = 1'b1; RegWriteD = 1'b1; FlagWriteD = 2'b11;
    tick();
    idleD(); StallE = 1'b1; ALUFlagsE = 4'b0010;
    expectSig(S_CEX, 32'h1, "stallCex0"); expectSig(S_RW, 32'h1, "stallRw0"); expectSig(S_FLG, 32'h0, "stallFlg0");
    tick();
    expectSig(S_CEX, 32'h1, "stallCex1"); expectSig(S_RW, 32'h1, "stallRw1"); expectSig(S_FLG, 32'h0, "stallFlg1");
    tick();
    StallE = 1'b0;
    expectSig(S_CEX, 32'h1, "stallCex2"); expectSig(S_RW, 32'h1, "stallRw2"); expectSig(S_FLG, 32'h0, "stallFlg2");
    tick();
    ALUFlagsE = 4'h0;
    expectSig(S_FLG, 32'h2, "stallFlgUpd"); expectSig(S_RW, 32'h2, "stallRwOut"); expectSig(S_CEX, 32'h0, "stallCexOut");
    tick();
    expectSig(S_RW, 32'h4, "stallRwS2"); expectSig(S_FLG, 32'h2, "stallFlgHold"); tick();
    expectSig(S_RW, 32'h8, "stallRwS3"); expectSig(S_RET, 32'h0, "stallRet0"); tick();
    expectSig(S_RET, 32'h1, "stallRet1"); tick();
    expectSig(S_RET, 32'h1, "stallRetOnce"); tick();

    // Flush beats stall
    doReset();
    ValidD = 1'b1; RegWriteD = 1'b1; FlagWriteD = 2'b11;
    tick();
    idleD(); StallE = 1'b1; FlushE = 1'b1; ALUFlagsE = 4'hF;
    expectSig(S_CEX, 32'h1, "flushCexBefore");
    tick();
    StallE = 1'b0; FlushE = 1'b0;
    expectSig(S_CEX, 32'h0, "flushBubble"); expectSig(S_FLG, 32'h0, "flushFlg"); expectSig(S_RW, 32'h0, "flushRw");
    tick();
    ALUFlagsE = 4'h0;
    expectSig(S_FLG, 32'h0, "flushFlg2"); expectSig(S_RW, 32'h0, "flushRw2");
    tick(); tick(); tick();
    expectSig(S_RET, 32'h0, "flushRet"); tick();

    // PC write in flight and control bundle shift
    doReset();
    ValidD = 1'b1; PCSrcD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; CtrlD = 4'hA;
    expectSig(S_PEND, 32'h1, "pendD");
    tick();
    idleD(); BranchD = 1'b1; CondD = 4'b0001;
    expectSig(S_PEND, 32'h1, "pendE"); expectSig(S_PCS, 32'h1, "pcs0");
    expectSig(S_MW, 32'h1, "mw0"); expectSig(S_CTRL, 32'h000A, "ctrl0"); expectSig(S_BR, 32'h0, "brInvalidD");
    tick();
    idleD();
    expectSig(S_PEND, 32'h1, "pend1"); expectSig(S_PCS, 32'h2, "pcs1");
    expectSig(S_MW, 32'h2, "mw1"); expectSig(S_CTRL, 32'h00A0, "ctrl1");
    tick();
    expectSig(S_PEND, 32'h1, "pend2"); expectSig(S_PCS, 32'h4, "pcs2");
    expectSig(S_MW, 32'h4, "mw2"); expectSig(S_CTRL, 32'h0A00, "ctrl2");
    tick();
    expectSig(S_PEND, 32'h0, "pendW"); expectSig(S_PCS, 32'h8, "pcs3");
    expectSig(S_MW, 32'h8, "mw3"); expectSig(S_CTRL, 32'hA000, "ctrl3");
    tick();

    // Saturating retirement counter (2 bits)
    doReset();
    for (int k = 0; k < 5; k++) begin
      idleD(); ValidD = 1'b1; RegWriteD = 1'b1;
      if (k == 4) expectSig(S_RET, 32'h0, "satRet0");
      tick();
    end
    idleD();
    expectSig(S_RET, 32'h1, "satRet1"); tick();
    expectSig(S_RET, 32'h2, "satRet2"); tick();
    expectSig(S_RET, 32'h3, "satRet3"); tick();
    expectSig(S_RET, 32'h3, "satRet4"); tick();
    expectSig(S_RET, 32'h3, "satRet5"); tick();

    // Full condition table against three flag patterns ({N,Z,C,V})
    doReset();
    condSweep(4'b1001, 16'hD65A);
    condSweep(4'b0110, 16'hE6A5);
    condSweep(4'b0010, 16'hD5A6);

    idleD();
    tick();
    @(negedge clk);
    #1;
    nTests++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL scoreboardDrain: actual=%0d required=0 pending expectations", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
